// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: miss-fill sequencer and arbiter for the icache and dcache.
// Grants the single 64-bit memory read port to one missing cache at a time,
// alternating on ties, runs the memory handshake, then pulses a one-cycle
// fill strobe with the captured line's index, tag and data. Also keeps
// saturating counters of fills started for each side.
module cache_fill_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic             i_miss,
  input  logic [31:0]      i_addr,
  input  logic             d_req,
  input  logic             d_miss,
  input  logic [31:0]      d_addr,
  output logic             mem_req,
  output logic [28:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [63:0]      mem_rdata,
  output logic             i_fill,
  output logic             d_fill,
  output logic [4:0]       fill_idx,
  output logic [23:0]      fill_tag,
  output logic [63:0]      fill_data,
  output logic             i_stall,
  output logic             d_stall,
  output logic [CNT_W-1:0] i_miss_cnt,
  output logic [CNT_W-1:0] d_miss_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] FILL = 2'd2;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        gnt;
  logic        last_grant;
  logic [28:0] line_addr;
  logic        ip;
  logic        dp;
  logic        grant_valid;
  logic        grant_side;
  logic        ack_in_req;

  // Byte-offset bits never leave the block; only whole lines are fetched.
  logic unused_byte_bits;
  assign unused_byte_bits = ^{i_addr[2:0], d_addr[2:0]};

  assign ip         = i_req & i_miss;
  assign dp         = d_req & d_miss;
  assign ack_in_req = (state == REQ) & mem_ack;

  // A cache stalls its stage for as long as it reports an active miss.
  assign i_stall = ip;
  assign d_stall = dp;

  // Arbitration: a lone requester wins; on a tie the side not served last wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_valid = 1'b0;
    grant_side  = GNT_I;
    if (state == IDLE) begin
      if (ip && dp) begin
        grant_valid = 1'b1;
        grant_side  = ~last_grant;
      end else if (ip) begin
        grant_valid = 1'b1;
        grant_side  = GNT_I;
      end else if (dp) begin
        grant_valid = 1'b1;
        grant_side  = GNT_D;
      end
    end
  end

  // Next-state logic: IDLE -> REQ on grant, REQ -> FILL on ack, FILL -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = REQ;
      REQ:     if (mem_ack)     state_nxt = FILL;
      FILL:                     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      state <= state_nxt;
    end
  end

  // Latch the winner's line address and grant so a withdrawn request still completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_addr  <= '0;
      gnt        <= GNT_I;
      last_grant <= GNT_D;
    end else if (grant_valid) begin
      line_addr  <= (grant_side == GNT_D) ? d_addr[31:3] : i_addr[31:3];
      gnt        <= grant_side;
      last_grant <= grant_side;
    end
  end

  // Register line data, index and tag on the ack; they hold outside the fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is a plain flop, not an array, so it is reset like the rest.
      fill_data <= '0;
      fill_idx  <= '0;
      fill_tag  <= '0;
    end else if (ack_in_req) begin
      fill_data <= mem_rdata;
      fill_idx  <= line_addr[4:0];
      fill_tag  <= line_addr[28:5];
    end
  end

  // Saturating per-side counters of fills started, bumped on each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_miss_cnt <= '0;
      d_miss_cnt <= '0;
    end else if (grant_valid) begin
      if (grant_side == GNT_I) begin
        if (i_miss_cnt != CNT_MAX) i_miss_cnt <= i_miss_cnt + CNT_ONE;
      end else begin
        if (d_miss_cnt != CNT_MAX) d_miss_cnt <= d_miss_cnt + CNT_ONE;
      end
    end
  end

  // Memory request and fill strobes are decoded straight from the state so
  // an asynchronous reset drops them immediately.
  assign mem_req  = (state == REQ);
  assign mem_addr = line_addr;
  assign i_fill   = (state == FILL) & (gnt == GNT_I);
  assign d_fill   = (state == FILL) & (gnt == GNT_D);

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Testbench for cache_fill_ctrl: directed stimulus with a scoreboard of
// expected memory requests and fills, popped by a negedge monitor.
module tb_cache_fill_ctrl;

  localparam int CNT_W = 2;

  typedef struct packed {
    logic        side;   // 0 = icache, 1 = dcache
    logic [4:0]  idx;
    logic [23:0] tag;
    logic [63:0] data;
  } fill_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_req, i_miss, d_req, d_miss;
  logic [31:0]      i_addr, d_addr;
  logic             mem_req, mem_ack;
  logic [28:0]      mem_addr;
  logic [63:0]      mem_rdata;
  logic             i_fill, d_fill;
  logic [4:0]       fill_idx;
  logic [23:0]      fill_tag;
  logic [63:0]      fill_data;
  logic             i_stall, d_stall;
  logic [CNT_W-1:0] i_miss_cnt, d_miss_cnt;

  int errors = 0;
  int checks = 0;

  logic [28:0] exp_mem[$];
  fill_t       exp_fill[$];

  cache_fill_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_miss(i_miss), .i_addr(i_addr),
    .d_req(d_req), .d_miss(d_miss), .d_addr(d_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .i_fill(i_fill), .d_fill(d_fill), .fill_idx(fill_idx), .fill_tag(fill_tag),
    .fill_data(fill_data), .i_stall(i_stall), .d_stall(d_stall),
    .i_miss_cnt(i_miss_cnt), .d_miss_cnt(d_miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic side, input logic [31:0] addr, input logic [63:0] data);
    fill_t f;
    f.side = side;
    f.idx  = addr[7:3];
    f.tag  = addr[31:8];
    f.data = data;
    exp_mem.push_back(addr[31:3]);
    exp_fill.push_back(f);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    i_req = 0; i_miss = 0; i_addr = '0;
    d_req = 0; d_miss = 0; d_addr = '0;
    mem_ack = 0; mem_rdata = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Monitor: compare every accepted memory request and every fill strobe
  // against the head of the matching expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req && mem_ack) begin
        if (exp_mem.size() == 0) begin
          check("unexpected_mem_req", {35'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("mem_addr", {35'd0, mem_addr}, {35'd0, exp_mem.pop_front()});
        end
      end
      if (i_fill || d_fill) begin
        check("one_fill_strobe", {63'd0, i_fill & d_fill}, 64'd0);
        if (exp_fill.size() == 0) begin
          check("unexpected_fill", {63'd0, d_fill}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          fill_t f;
          f = exp_fill.pop_front();
          check("fill_side", {63'd0, d_fill}, {63'd0, f.side});
          check("fill_idx",  {59'd0, fill_idx}, {59'd0, f.idx});
          check("fill_tag",  {40'd0, fill_tag}, {40'd0, f.tag});
          check("fill_data", fill_data, f.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fills;

    // ---- Reset values (checked while reset is held) ----
    rst_n = 1'b0;
    i_req = 0; i_miss = 0; i_addr = '0;
    d_req = 0; d_miss = 0; d_addr = '0;
    mem_ack = 0; mem_rdata = '0;
    tick();
    check("rst_mem_req",   {63'd0, mem_req}, 0);
    check("rst_fill",      {62'd0, i_fill, d_fill}, 0);
    check("rst_mem_addr",  {35'd0, mem_addr}, 0);
    check("rst_fill_idx",  {59'd0, fill_idx}, 0);
    check("rst_fill_tag",  {40'd0, fill_tag}, 0);
    check("rst_fill_data", fill_data, 0);
    check("rst_cnts",      {60'd0, i_miss_cnt, d_miss_cnt}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- Single imiss, ack two cycles after mem_req rises ----
    i_req = 1; i_miss = 1; i_addr = 32'h0000_1238;
    push(1'b0, 32'h0000_1238, 64'h0123_4567_89AB_CDEF);
    #1;
    check("s_i_stall", {63'd0, i_stall}, 1);
    check("s_c0_mem_req", {63'd0, mem_req}, 0);
    tick();                                   // cycle 1
    check("s_c1_mem_req", {63'd0, mem_req}, 1);
    check("s_mem_addr", {35'd0, mem_addr}, 64'h247);
    tick();                                   // cycle 2
    check("s_c2_mem_req", {63'd0, mem_req}, 1);
    tick();                                   // cycle 3: ack
    mem_ack = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
    tick();                                   // cycle 4: fill
    mem_ack = 0;
    check("s_i_fill", {63'd0, i_fill}, 1);
    check("s_c4_mem_req", {63'd0, mem_req}, 0);
    tick();                                   // cycle 5: tag array updated
    i_miss = 0;
    #1;
    check("s_i_stall_clr", {63'd0, i_stall}, 0);
    check("s_c5_fill", {63'd0, i_fill}, 0);
    tick();
    check("s_no_regrant", {63'd0, mem_req}, 0);
    check("s_i_cnt", {62'd0, i_miss_cnt}, 1);
    i_req = 0;

    // ---- Simultaneous misses after reset: icache first, then alternate ----
    apply_reset();
    i_req = 1; i_miss = 1; i_addr = 32'h100;
    d_req = 1; d_miss = 1; d_addr = 32'h208;
    push(1'b0, 32'h100, 64'hAAAA_0000_0000_0001);
    push(1'b1, 32'h208, 64'hBBBB_0000_0000_0002);
    push(1'b0, 32'h300, 64'hCCCC_0000_0000_0003);
    tick();                                   // c1: REQ for icache
    check("p_c1_addr", {35'd0, mem_addr}, 64'h20);
    mem_ack = 1; mem_rdata = 64'hAAAA_0000_0000_0001;
    tick();                                   // c2: i_fill
    mem_ack = 0;
    check("p_i_fill", {62'd0, i_fill, d_fill}, 2'b10);
    // The icache misses again on another line while the dcache still waits,
    // so the next IDLE cycle sees a tie with last_grant = I.
    i_addr = 32'h300;
    tick();                                   // c3: bubble
    check("p_bubble", {63'd0, mem_req}, 0);
    tick();                                   // c4: dcache wins the tie
    check("p_c4_req", {63'd0, mem_req}, 1);
    check("p_c4_addr", {35'd0, mem_addr}, 64'h41);
    mem_ack = 1; mem_rdata = 64'hBBBB_0000_0000_0002;
    tick();                                   // c5: d_fill
    mem_ack = 0;
    check("p_d_fill", {62'd0, i_fill, d_fill}, 2'b01);
    tick();                                   // c6: bubble, dcache line now present
    d_miss = 0;
    check("p_bubble2", {63'd0, mem_req}, 0);
    tick();                                   // c7: icache again
    check("p_c7_addr", {35'd0, mem_addr}, 64'h60);
    mem_ack = 1; mem_rdata = 64'hCCCC_0000_0000_0003;
    tick();                                   // c8: i_fill
    mem_ack = 0;
    check("p_i_fill2", {62'd0, i_fill, d_fill}, 2'b10);
    tick();
    i_miss = 0; i_req = 0; d_req = 0;
    tick();
    check("p_idle", {63'd0, mem_req}, 0);
    check("p_cnts", {60'd0, i_miss_cnt, d_miss_cnt}, {60'd0, 2'd2, 2'd1});

    // ---- Requester withdraws during REQ ----
    apply_reset();
    d_req = 1; d_miss = 1; d_addr = 32'h0000_ABC8;
    push(1'b1, 32'h0000_ABC8, 64'hDEAD_BEEF_0000_0005);
    tick();                                   // c1: REQ
    d_req = 0; d_addr = 32'h5555_0000;
    #1;
    check("w_d_stall", {63'd0, d_stall}, 0);
    check("w_c1_req", {63'd0, mem_req}, 1);
    tick();                                   // c2
    check("w_addr_stable", {35'd0, mem_addr}, 64'h1579);
    mem_ack = 1; mem_rdata = 64'hDEAD_BEEF_0000_0005;
    tick();                                   // c3: fill to captured line
    mem_ack = 0;
    check("w_d_fill", {63'd0, d_fill}, 1);
    tick();
    d_miss = 0;
    check("w_idle", {63'd0, mem_req}, 0);
    check("w_d_cnt", {62'd0, d_miss_cnt}, 1);

    // ---- Reset during REQ ----
    i_req = 1; i_miss = 1; i_addr = 32'h40;
    tick();                                   // c1: REQ
    check("r_req", {63'd0, mem_req}, 1);
    #2;
    rst_n = 0;
    #1;
    check("r_async_drop", {63'd0, mem_req}, 0);
    check("r_cnts", {60'd0, i_miss_cnt, d_miss_cnt}, 0);
    i_req = 0; i_miss = 0; mem_ack = 1;
    tick();
    tick();
    rst_n = 1;
    fills = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      fills += int'(i_fill | d_fill);
    end
    check("r_no_fill", fills, 0);
    mem_ack = 0;

    // ---- Zero-wait memory and counter saturation (CNT_W = 2) ----
    apply_reset();
    mem_ack = 1;
    for (int n = 0; n < 5; n++) begin
      logic [31:0] a;
      logic [63:0] dat;
      a   = 32'h1000 + 32'(n * 8);
      dat = 64'hF00D_0000_0000_0000 + 64'(n);
      d_req = 1; d_miss = 1; d_addr = a; mem_rdata = dat;
      push(1'b1, a, dat);
      tick();                                 // REQ, accepted this cycle
      check("z_req_high", {63'd0, mem_req}, 1);
      tick();                                 // FILL
      check("z_req_low", {63'd0, mem_req}, 0);
      check("z_d_fill", {63'd0, d_fill}, 1);
      d_req = 0; d_miss = 0;
      check("z_d_cnt", {62'd0, d_miss_cnt}, (n + 1 > 3) ? 3 : n + 1);
      tick();                                 // IDLE
    end
    mem_ack = 0;
    check("z_i_cnt", {62'd0, i_miss_cnt}, 0);
    tick();

    check("exp_mem_drained", exp_mem.size(), 0);
    check("exp_fill_drained", exp_fill.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
